// File: rtl/cal_sched.sv
// Round-robin scheduler sharing one external add/sub datapath among N_REQ requesters.
// Optional completed-operation counter (done_cnt) enabled by defining CAL_SCHED_CNT_EN.
module cal_sched #(
  parameter int unsigned N_REQ = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [9*N_REQ-1:0]     req_op,
  output logic [N_REQ-1:0]       req_ready,
  output logic [1:0]             cal_a,
  output logic [1:0]             cal_b,
  output logic [1:0]             cal_c,
  output logic [1:0]             cal_d,
  output logic                   cal_sel,
  input  logic [7:0]             cal_out,
  output logic                   rsp_valid,
  output logic [1:0]             rsp_id,
  output logic [7:0]             rsp_data,
  input  logic                   rsp_ready
`ifdef CAL_SCHED_CNT_EN
  ,
  output logic [15:0]            done_cnt
`endif
);

  localparam int unsigned ID_W  = 2;
  localparam int unsigned OP_W  = 9;
  localparam int unsigned PAD_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t            state;
  logic [ID_W-1:0]   last_id;
  logic [ID_W-1:0]   win_id;
  logic              win_found;
  logic [PAD_W-1:0]  vld_pad;
  logic [OP_W-1:0]   win_op;
  logic              xfer;
  int unsigned       idx;

  // Round-robin search starting one past the last granted requester.
  always_comb begin
    vld_pad   = PAD_W'(req_valid);
    win_found = 1'b0;
    win_id    = '0;
    idx       = 0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      idx = (32'(last_id) + 32'd1 + k) % N_REQ;
      if (!win_found && vld_pad[ID_W'(idx)]) begin
        win_found = 1'b1;
        win_id    = ID_W'(idx);
      end
    end
  end

  always_comb begin
    win_op = OP_W'(req_op >> (OP_W * 32'(win_id)));
  end

  // Grant strobe is combinational and forced low while reset is asserted.
  always_comb begin
    req_ready = '0;
    if (rst_n && (state == IDLE) && win_found) begin
      req_ready = N_REQ'(1) << win_id;
    end
  end

  assign xfer = |(req_valid & req_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      last_id   <= ID_W'(N_REQ - 1);
      cal_a     <= '0;
      cal_b     <= '0;
      cal_c     <= '0;
      cal_d     <= '0;
      cal_sel   <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (xfer) begin
            cal_sel <= win_op[0];
            cal_a   <= win_op[2:1];
            cal_b   <= win_op[4:3];
            cal_c   <= win_op[6:5];
            cal_d   <= win_op[8:7];
            last_id <= win_id;
            rsp_id  <= win_id;
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          rsp_data  <= cal_out;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_valid && rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CAL_SCHED_CNT_EN
  // Saturating count of accepted responses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_cnt <= '0;
    end else if (rsp_valid && rsp_ready && (done_cnt != 16'hFFFF)) begin
      done_cnt <= done_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cal_sched.sv
// Self-checking bench for cal_sched: vector table plus reset/backpressure sequences,
// with a response scoreboard queue.
module tb_cal_sched;
  localparam int unsigned N_REQ = 4;
  localparam int unsigned N_VEC = 11;

  logic                clk = 1'b0;
  logic                rst_n = 1'b1;
  logic [N_REQ-1:0]    req_valid = '0;
  logic [9*N_REQ-1:0]  req_op = '0;
  logic [N_REQ-1:0]    req_ready;
  logic [1:0]          cal_a, cal_b, cal_c, cal_d;
  logic                cal_sel;
  logic [7:0]          cal_out;
  logic                rsp_valid;
  logic [1:0]          rsp_id;
  logic [7:0]          rsp_data;
  logic                rsp_ready = 1'b1;
`ifdef CAL_SCHED_CNT_EN
  logic [15:0]         done_cnt;
`endif

  cal_sched #(.N_REQ(N_REQ)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_op    (req_op),
    .req_ready (req_ready),
    .cal_a     (cal_a),
    .cal_b     (cal_b),
    .cal_c     (cal_c),
    .cal_d     (cal_d),
    .cal_sel   (cal_sel),
    .cal_out   (cal_out),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .rsp_ready (rsp_ready)
`ifdef CAL_SCHED_CNT_EN
    ,
    .done_cnt  (done_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  vld;
    logic [35:0] op;
    logic [1:0]  exp_id;
    bit          chk_gap;
  } vec_t;

  vec_t        tbl [N_VEC];
  int          n_tests = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          prev_grant = 0;
  bit          have_prev = 0;
  int          exp_done = 0;
  logic [9:0]  exp_q [$];
  logic        stub_en = 1'b0;
  logic [7:0]  stub_val = 8'h00;

  // Datapath stub: {a,b} +/- {c,d}, with an override for fixed-value tests.
  function automatic logic [7:0] dp(input logic [8:0] op);
    logic [7:0] x, y;
    x = {4'b0, op[2:1], op[4:3]};
    y = {4'b0, op[6:5], op[8:7]};
    return op[0] ? (x - y) : (x + y);
  endfunction

  always_comb cal_out = stub_en ? stub_val : dp({cal_d, cal_c, cal_b, cal_a, cal_sel});

  always @(posedge clk) cyc <= cyc + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_rsp();
    logic [9:0] e;
    if (exp_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_empty: got response id %0d expected none", rsp_id);
    end else begin
      e = exp_q.pop_front();
      chk("rsp_id", 32'(rsp_id), 32'(e[9:8]));
      chk("rsp_data", 32'(rsp_data), 32'(e[7:0]));
    end
  endtask

  function automatic logic [8:0] op_of(input logic [35:0] op, input logic [1:0] id);
    logic [35:0] sh;
    sh = op >> (9 * 32'(id));
    return sh[8:0];
  endfunction

  // One complete transaction: grant, ISSUE, RESP accepted immediately.
  task automatic run_txn(input vec_t v);
    int n;
    req_valid = v.vld;
    req_op    = v.op;
    #1;
    n = 0;
    while (req_ready == '0 && n < 5) begin
      step();
      n++;
    end
    chk("grant", 32'(req_ready), 32'(1) << v.exp_id);
    if (v.chk_gap && have_prev) chk("grant_gap", 32'(cyc - prev_grant), 32'd3);
    prev_grant = cyc;
    have_prev  = 1'b1;
    exp_q.push_back({v.exp_id, dp(op_of(v.op, v.exp_id))});
    step();
    chk("busy_ready_issue", 32'(req_ready), 32'd0);
    n = 0;
    while (!rsp_valid && n < 4) begin
      step();
      n++;
    end
    chk("rsp_latency", 32'(n), 32'd1);
    chk("rsp_valid", 32'(rsp_valid), 32'd1);
    chk("busy_ready_resp", 32'(req_ready), 32'd0);
    chk_rsp();
    if (rsp_valid && rsp_ready) exp_done++;
    step();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    chk({tag, "_cal"}, 32'({cal_a, cal_b, cal_c, cal_d, cal_sel}), 32'd0);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_rsp_id"}, 32'(rsp_id), 32'd0);
    chk({tag, "_rsp_data"}, 32'(rsp_data), 32'd0);
`ifdef CAL_SCHED_CNT_EN
    chk({tag, "_done_cnt"}, 32'(done_cnt), 32'd0);
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       v;
    logic [9:0] e;

    tbl[0]  = '{4'b1111, 36'h0, 2'd1, 1'b0};
    tbl[1]  = '{4'b1111, 36'h0, 2'd2, 1'b1};
    tbl[2]  = '{4'b1111, 36'h0, 2'd3, 1'b1};
    tbl[3]  = '{4'b1111, 36'h0, 2'd0, 1'b1};
    tbl[4]  = '{4'b1000, 36'h0, 2'd3, 1'b1};
    tbl[5]  = '{4'b0100, 36'h0, 2'd2, 1'b1};
    tbl[6]  = '{4'b0011, 36'h0, 2'd0, 1'b1};
    tbl[7]  = '{4'b0101, 36'h0, 2'd2, 1'b1};
    tbl[8]  = '{4'b1001, 36'h0, 2'd3, 1'b1};
    tbl[9]  = '{4'b0110, 36'h0, 2'd1, 1'b1};
    tbl[10] = '{4'b0001, 36'h0, 2'd0, 1'b1};
    for (int i = 0; i < int'(N_VEC); i++) tbl[i].op = 36'({$urandom(), $urandom()});

    // Reset applied between edges with requests pending.
    #3 rst_n = 1'b0;
    req_valid = 4'b1111;
    #1;
    chk_reset_outputs("reset");
    step();
    step();
    rst_n = 1'b0;
    req_valid = '0;
    #1 rst_n = 1'b1;

    // Single request with a fixed datapath result.
    stub_en  = 1'b1;
    stub_val = 8'hA5;
    req_op    = 36'h073;
    req_valid = 4'b0001;
    #1;
    chk("single_grant", 32'(req_ready), 32'h1);
    step();
    req_valid = '0;
    chk("single_cal", 32'({cal_a, cal_b, cal_c, cal_d, cal_sel}), 32'b01_10_11_00_1);
    chk("single_issue_rsp", 32'(rsp_valid), 32'd0);
    step();
    chk("single_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("single_rsp_id", 32'(rsp_id), 32'd0);
    chk("single_rsp_data", 32'(rsp_data), 32'hA5);
    exp_done++;
    step();
    stub_en = 1'b0;

    for (int i = 0; i < int'(N_VEC); i++) run_txn(tbl[i]);

    // Nothing requested: no grant, no response.
    req_valid = '0;
    #1;
    chk("idle_no_grant", 32'(req_ready), 32'd0);
    step();
    chk("idle_no_rsp", 32'(rsp_valid), 32'd0);

    // Backpressure: response held steady, no further grants.
    rsp_ready = 1'b0;
    req_valid = 4'b0010;
    req_op    = 36'({$urandom(), $urandom()});
    #1;
    chk("bp_grant", 32'(req_ready), 32'h2);
    exp_q.push_back({2'd1, dp(op_of(req_op, 2'd1))});
    step();
    req_valid = 4'b1111;
    step();
    chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
    e = exp_q.pop_front();
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold_valid", 32'(rsp_valid), 32'd1);
      chk("bp_hold_id", 32'(rsp_id), 32'(e[9:8]));
      chk("bp_hold_data", 32'(rsp_data), 32'(e[7:0]));
      chk("bp_no_grant", 32'(req_ready), 32'd0);
      step();
    end
    rsp_ready = 1'b1;
    exp_done++;
    step();
    chk("bp_release_grant", 32'(req_ready), 32'h4);
    v = '{4'b1111, req_op, 2'd2, 1'b0};
    run_txn(v);

    // Reset during ISSUE aborts the operation; next grant favours id0.
    req_valid = 4'b1000;
    #1;
    chk("mid_grant", 32'(req_ready), 32'h8);
    step();
    #1 rst_n = 1'b0;
    #1;
    chk_reset_outputs("mid_reset");
    exp_done  = 0;
    have_prev = 1'b0;
    step();
    rst_n = 1'b1;
    req_valid = '0;
    #1;
    chk("mid_no_rsp", 32'(rsp_valid), 32'd0);
    v = '{4'b0101, 36'({$urandom(), $urandom()}), 2'd0, 1'b0};
    run_txn(v);
    req_valid = '0;

`ifdef CAL_SCHED_CNT_EN
    chk("done_cnt", 32'(done_cnt), 32'(exp_done));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cal_sched.md
CAL_SCHED -- requirements
Module: cal_sched

Interface
REQ-001 SHALL have parameter N_REQ, default 4: number of requesters (legal 2..4); id width is 2 bits.
REQ-002 SHALL have port clk, input, 1 bit: single clock, all state on rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have port req_valid, input, N_REQ bits: per-requester operation request.
REQ-005 SHALL have port req_op, input, 9*N_REQ bits: requester i packed at [9i+8:9i]: bit0 = add_sub_sel, [2:1] = a, [4:3] = b, [6:5] = c, [8:7] = d.
REQ-006 SHALL have port req_ready, output, N_REQ bits: grant/accept strobe, one-hot or zero.
REQ-007 SHALL have ports cal_a, cal_b, cal_c, cal_d, outputs, 2 bits each: operands to the shared add/sub datapath.
REQ-008 SHALL have port cal_sel, output, 1 bit: add/sub select to the datapath.
REQ-009 SHALL have port cal_out, input, 8 bits: combinational datapath result.
REQ-010 SHALL have port rsp_valid, output, 1 bit: result available.
REQ-011 SHALL have port rsp_id, output, 2 bits: requester index owning the result.
REQ-012 SHALL have port rsp_data, output, 8 bits: registered result.
REQ-013 SHALL have port rsp_ready, input, 1 bit: result consumer accept.

Function
REQ-014 SHALL implement FSM states IDLE, ISSUE, RESP; transitions: IDLE->ISSUE on any req_valid, ISSUE->RESP unconditionally, RESP->IDLE on rsp_valid&rsp_ready, otherwise hold.
REQ-015 SHALL, in IDLE, select the winner round-robin: first set req_valid bit searching upward from (last_id+1) mod N_REQ.
REQ-016 SHALL drive req_ready combinationally high only for the winner, only in IDLE; transfer = req_valid[i]&req_ready[i].
REQ-017 SHALL, on transfer, latch the winner's 9-bit op into cal_* registers and the winner index into last_id and rsp_id.
REQ-018 SHALL hold cal_* stable through ISSUE and RESP and keep the last values in IDLE.
REQ-019 SHALL sample cal_out into rsp_data at the end of ISSUE; rsp_valid high from the next cycle (grant cycle T -> rsp_valid at T+2).
REQ-020 SHALL hold rsp_valid, rsp_id, rsp_data constant while rsp_valid&!rsp_ready (backpressure); no new grant until the response is accepted.
REQ-021 SHALL pass cal_out through unmodified; subtraction wrap/sign is the datapath's, not reinterpreted.
REQ-022 SHALL ignore req_valid changes outside IDLE; a requester withdrawing valid before grant loses nothing and is not granted.
REQ-023 SHALL sustain at most one operation per 3 cycles (IDLE, ISSUE, RESP with rsp_ready=1).
REQ-024 SHALL treat req_valid bits at index >= N_REQ as absent.

Reset
REQ-025 SHALL on rst_n low, immediately and regardless of state: state=IDLE, req_ready=0, cal_a..cal_d=0, cal_sel=0, rsp_valid=0, rsp_id=0, rsp_data=0, last_id=N_REQ-1.
REQ-026 SHALL abort any in-flight operation on reset with no response issued; first grant after reset favours requester 0.

Configuration
REQ-027 SHALL, with macro CAL_SCHED_CNT_EN defined, add output done_cnt (16 bits, reset 0) incrementing on every rsp_valid&rsp_ready and saturating at 16'hFFFF.
REQ-028 SHALL, without CAL_SCHED_CNT_EN, have no done_cnt port or counter logic; all other behaviour identical.

Verification
REQ-029 Single request: req_valid=4'b0001, op0 a=1,b=2,c=3,d=0,sel=1, stub cal_out=8'hA5 -> req_ready=4'b0001 at T; cal_a=1,cal_b=2,cal_c=3,cal_d=0,cal_sel=1 at T+1; rsp_valid=1, rsp_id=0, rsp_data=8'hA5 at T+2.
REQ-030 Fairness: req_valid=4'b1111 held, rsp_ready=1 -> grant order 0,1,2,3,0, one grant every 3 cycles.
REQ-031 Backpressure: rsp_ready=0 for 5 cycles after rsp_valid -> rsp_* stable, req_ready=0; rsp_ready=1 -> IDLE next cycle, next grant that cycle.
REQ-032 Reset mid-op: rst_n low during ISSUE -> all outputs at reset values without a clock edge; next request from id2 and id0 together grants id0.
REQ-033 Sparse: req_valid=4'b0100 after last grant to id3 -> grant id2; with CAL_SCHED_CNT_EN, done_cnt increments by 1 per accepted response.
